// File: rtl/reverse_pkg.sv
// Shared definitions for the reverse_stream reorder stage: mode encodings
// and the frame-tracking FSM state type.
package reverse_pkg;

    // Reorder mode carried with every beat
    typedef logic [1:0] rev_mode_t;

    localparam rev_mode_t REV_PASS  = 2'd0;  // data unchanged
    localparam rev_mode_t REV_BIT   = 2'd1;  // full-width bit reverse
    localparam rev_mode_t REV_GRP   = 2'd2;  // group order reverse
    localparam rev_mode_t REV_INGRP = 2'd3;  // bit reverse inside each group

    // Frame tracking state
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_t;

endpackage

// File: rtl/reverse_xform.sv
// Purely combinational reorder network. All four candidate reorderings are
// plain wiring; the mode only steers the final multiplexer.
module reverse_xform
    import reverse_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GRAN  = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result
);

    localparam int NGRP = WIDTH / GRAN;

    // A beat that does not split into whole groups has no meaningful group order
    if ((WIDTH % GRAN) != 0) begin : g_bad_gran
        $error("reverse_xform: WIDTH (%0d) must be a multiple of GRAN (%0d)", WIDTH, GRAN);
    end

    logic [WIDTH-1:0] bit_rev;
    logic [WIDTH-1:0] grp_rev;
    logic [WIDTH-1:0] in_grp_rev;

    // Full bit reverse: bit i takes bit WIDTH-1-i
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bit_rev[i] = data[WIDTH-1-i];
    end

    // Group order reverse and bit reverse within each group
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        assign grp_rev[g*GRAN +: GRAN] = data[(NGRP-1-g)*GRAN +: GRAN];
        for (genvar b = 0; b < GRAN; b++) begin : g_in
            assign in_grp_rev[g*GRAN + b] = data[g*GRAN + GRAN - 1 - b];
        end
    end

    // Select the reordering requested for this beat
    always_comb begin
        result = data;
        case (rev_mode_t'(mode))
            REV_BIT:   result = bit_rev;
            REV_GRP:   result = grp_rev;
            REV_INGRP: result = in_grp_rev;
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/reverse_stream.sv
// Pipelined multi-mode reorder stage on a valid/ready stream. The reorder
// mode is latched at each frame start; beats are transformed on entry and
// held in a two-entry buffer (output register plus skid register) so the
// upstream ready can be fully registered.
module reverse_stream
    import reverse_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GRAN  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [1:0]       out_mode,
    input  logic             err_clr,
    output logic             mode_err,
    output logic [CNT_W-1:0] frame_cnt
);

    frame_state_t state;
    frame_state_t state_next;
    rev_mode_t    latched_mode;
    rev_mode_t    latched_next;
    rev_mode_t    beat_mode;
    logic         err_event;

    logic             accept;
    logic             out_fire;
    logic             out_free;
    logic             skid_valid;
    logic             skid_valid_next;
    logic [WIDTH-1:0] skid_data;
    logic             skid_sop;
    logic             skid_eop;
    rev_mode_t        skid_mode;
    logic [WIDTH-1:0] xf_data;

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    // The output register can take a new beat when it is empty or being drained
    assign out_free = ~out_valid | out_ready;

    // Frame state and latched mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            latched_mode <= REV_PASS;
        end else begin
            state        <= state_next;
            latched_mode <= latched_next;
        end
    end

    // Frame tracking: pick the mode for the accepted beat and flag protocol errors
    always_comb begin
        state_next   = state;
        latched_next = latched_mode;
        beat_mode    = latched_mode;
        err_event    = 1'b0;
        if (accept) begin
            if (in_sop) begin
                beat_mode    = rev_mode_t'(mode);
                latched_next = rev_mode_t'(mode);
                if (state == ST_IN_FRAME) begin
                    err_event = 1'b1;
                end
                state_next = in_eop ? ST_IDLE : ST_IN_FRAME;
            end else if (state == ST_IN_FRAME) begin
                if (rev_mode_t'(mode) != latched_mode) begin
                    err_event = 1'b1;
                end
                if (in_eop) begin
                    state_next = ST_IDLE;
                end
            end else begin
                err_event = 1'b1;
            end
        end
    end

    reverse_xform #(
        .WIDTH (WIDTH),
        .GRAN  (GRAN)
    ) u_xform (
        .mode   (beat_mode),
        .data   (in_data),
        .result (xf_data)
    );

    // The skid entry empties whenever the output register can accept, and
    // fills only when a beat arrives while the output register is stalled
    always_comb begin
        skid_valid_next = skid_valid;
        if (out_free) begin
            skid_valid_next = 1'b0;
        end else if (accept) begin
            skid_valid_next = 1'b1;
        end
    end

    // Output register: refill from the skid entry first to keep beat order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_mode  <= REV_PASS;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_sop   <= skid_sop;
                out_eop   <= skid_eop;
                out_mode  <= skid_mode;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= xf_data;
                out_sop   <= in_sop;
                out_eop   <= in_eop;
                out_mode  <= beat_mode;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Skid register captures the one beat accepted while the output stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sop   <= 1'b0;
            skid_eop   <= 1'b0;
            skid_mode  <= REV_PASS;
        end else begin
            skid_valid <= skid_valid_next;
            if (!out_free && accept) begin
                skid_data <= xf_data;
                skid_sop  <= in_sop;
                skid_eop  <= in_eop;
                skid_mode <= beat_mode;
            end
        end
    end

    // Registered upstream ready mirrors an empty skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= ~skid_valid_next;
        end
    end

    // Sticky error flag; a new error in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_err <= 1'b0;
        end else if (err_event) begin
            mode_err <= 1'b1;
        end else if (err_clr) begin
            mode_err <= 1'b0;
        end
    end

    // Count frames as their last beat leaves the stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (out_fire && out_eop) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule
